imgproc_gen: RTL

IMGPROC_GEN -- requirements
Module: imgproc_gen

---
 rtl/imgproc_pkg.sv | 5 +
 rtl/imgproc_hwin.sv | 28 ++
 rtl/imgproc_gen.sv | 102 ++++++++++
 3 files changed

// File: rtl/imgproc_pkg.sv
// imgproc_pkg: mode encoding and FSM state type shared by the image generator blocks
package imgproc_pkg;
  typedef enum logic [1:0] {MODE_COPY, MODE_INV, MODE_THR, MODE_SMOOTH} mode_t;
  typedef enum logic [2:0] {IDLE, FETCH, OUT, TAIL, DONE} state_t;
endpackage

// File: rtl/imgproc_hwin.sv
// imgproc_hwin: 3-tap horizontal window with edge replication and 1-2-1 smoothing
module imgproc_hwin #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift,
  input  logic          first,
  input  logic [DW-1:0] pix,
  output logic [DW-1:0] mid_pix,
  output logic [DW-1:0] tail_pix
);
  logic [DW-1:0] l, c;
  logic [DW+1:0] mid_sum, tail_sum;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      l <= '0;
      c <= '0;
    end else if (shift) begin
      l <= first ? pix : c;
      c <= pix;
    end
  // incoming pixel is the right tap; at the row end the centre is replicated instead
  assign mid_sum  = {2'b0, l} + {1'b0, c, 1'b0} + {2'b0, pix};
  assign tail_sum = {2'b0, l} + {1'b0, c, 1'b0} + {2'b0, c};
  assign mid_pix  = mid_sum[DW+1:2];
  assign tail_pix = tail_sum[DW+1:2];
endmodule

// File: rtl/imgproc_gen.sv
// imgproc_gen: fetches a frame pixel by pixel and writes copy/invert/threshold/smoothed results
module imgproc_gen
  import imgproc_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int DW    = 8,
  parameter int AW    = $clog2(IMG_W*IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] thr,
  output logic          request,
  output logic [AW-1:0] orig_addr,
  input  logic          orig_ready,
  input  logic [DW-1:0] orig_data,
  output logic          imgproc_ready,
  output logic [AW-1:0] imgproc_addr,
  output logic [DW-1:0] imgproc_data,
  output logic          finish
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  state_t state_q, state_d;
  mode_t mode_r;
  logic [DW-1:0] thr_r, pix_res, mid_pix, tail_pix;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic idle, cap, smooth, last_col, last_pix, emit, to_tail, adv;
  assign idle     = state_q == IDLE || state_q == DONE;
  assign request  = state_q == FETCH;
  assign cap      = request && orig_ready;
  assign smooth   = mode_r == MODE_SMOOTH;
  assign last_col = col == CW'(IMG_W-1);
  assign last_pix = last_col && row == RW'(IMG_H-1);
  assign to_tail  = state_q == OUT && smooth && last_col;
  assign adv      = (state_q == OUT && !to_tail) || state_q == TAIL;
  // smoothing lags one column, so column 0's capture has nothing to emit yet
  assign emit     = cap && !(smooth && col == '0);
  assign pix_res  = mode_r == MODE_INV ? ~orig_data :
                    mode_r == MODE_THR ? {DW{orig_data >= thr_r}} :
                    smooth ? mid_pix : orig_data;
  imgproc_hwin #(.DW(DW)) u_hwin (
    .clk(clk),
    .rst(rst),
    .shift(cap),
    .first(col == '0),
    .pix(orig_data),
    .mid_pix(mid_pix),
    .tail_pix(tail_pix)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? FETCH : state_q;
      FETCH:      state_d = orig_ready ? OUT : FETCH;
      OUT:        state_d = to_tail ? TAIL : last_pix ? DONE : FETCH;
      TAIL:       state_d = last_pix ? DONE : FETCH;
      default:    state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q       <= IDLE;
      mode_r        <= MODE_COPY;
      thr_r         <= '0;
      orig_addr     <= '0;
      col           <= '0;
      row           <= '0;
      imgproc_ready <= 1'b0;
      imgproc_addr  <= '0;
      imgproc_data  <= '0;
      finish        <= 1'b0;
    end else begin
      state_q       <= state_d;
      imgproc_ready <= emit || to_tail;
      if (idle && start) begin
        mode_r    <= mode_t'(mode);
        thr_r     <= thr;
        orig_addr <= '0;
        col       <= '0;
        row       <= '0;
      end
      if (emit) begin
        imgproc_addr <= smooth ? orig_addr - AW'(1) : orig_addr;
        imgproc_data <= pix_res;
      end
      if (to_tail) begin
        imgproc_addr <= orig_addr;
        imgproc_data <= tail_pix;
      end
      if (adv) begin
        orig_addr <= orig_addr + AW'(1);
        col       <= last_col ? '0 : col + CW'(1);
        row       <= last_col ? row + RW'(1) : row;
      end
      if (idle && start) finish <= 1'b0;
      else if (adv && last_pix) finish <= 1'b1;
    end
endmodule
